pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 32, meaning width of excp_pc/new_pc.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the consecutive-stall-cycle limit that raises stall_timeout (legal range 1..65535).
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port stallreq_id  input  1  ID stage stall request (load-use hazard).
REQ-006 The block SHALL have port stallreq_ex  input  1  EX stage stall request (multi-cycle mult/div busy).
REQ-007 The block SHALL have port stallreq_mem  input  1  MEM stage stall request (data bus wait).
REQ-008 The block SHALL have port excp_valid  input  1  exception committed in MEM stage, single-cycle pulse.
REQ-009 The block SHALL have port excp_pc  input  PC_WIDTH  handler address, valid when excp_valid=1.
REQ-010 The block SHALL have port stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-011 The block SHALL have port flush  output  1  clear all pipeline registers including MEM/WB (register file and hi/lo write enables forced 0 downstream).
REQ-012 The block SHALL have port new_pc  output  PC_WIDTH  redirect target, valid with new_pc_valid.
REQ-013 The block SHALL have port new_pc_valid  output  1  PC redirect strobe.
REQ-014 The block SHALL have port stall_cycles  output  32  saturating count of cycles with stall!=0.
REQ-015 The block SHALL have port stall_timeout  output  1  sticky flag: stall held TIMEOUT consecutive cycles.

Function
REQ-016 The block SHALL implement FSM states RUN and FLUSH; reset state RUN.
REQ-017 In RUN with excp_valid=0, stall SHALL be combinational: stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 6'b000000.
REQ-018 Priority SHALL be stallreq_mem > stallreq_ex > stallreq_id when several are asserted together.
REQ-019 In RUN, excp_valid=1 SHALL override all stall requests: stall=0 that cycle, excp_pc latched, next state FLUSH.
REQ-020 In FLUSH (exactly one cycle), outputs SHALL be flush=1, new_pc_valid=1, new_pc=latched excp_pc, stall=0; next state RUN.
REQ-021 flush and new_pc_valid SHALL be 0 in RUN; new_pc SHALL hold its last latched value outside FLUSH.
REQ-022 excp_valid and stall requests arriving during FLUSH SHALL be ignored (the flushed stages cannot legally raise them).
REQ-023 A consecutive-stall counter (16-bit) SHALL increment each cycle stall!=0 and clear to 0 in any cycle stall==0.
REQ-024 stall_timeout SHALL set in the cycle after the consecutive counter reaches TIMEOUT and remain 1 until reset.
REQ-025 stall_cycles SHALL increment by 1 per cycle with stall!=0 and saturate at 32'hFFFFFFFF without wrap.
REQ-026 The consecutive counter SHALL saturate at TIMEOUT (no wrap) while the stall persists.

Reset
REQ-027 While rst_n=0 at a clock edge: state RUN, latched pc 0, new_pc 0, counters 0, stall_timeout 0.
REQ-028 While rst_n=0, outputs SHALL read stall=0, flush=0, new_pc_valid=0 regardless of inputs.
REQ-029 Reset asserted in FLUSH SHALL abort the redirect; no new_pc_valid pulse after reset release.

Verification
REQ-030 stallreq_id=1 for 3 cycles -> stall=6'b000111 for those 3 cycles, stall_cycles=3, then stall=0.
REQ-031 stallreq_id=stallreq_ex=stallreq_mem=1 same cycle -> stall=6'b011111.
REQ-032 excp_valid=1, excp_pc=32'hBFC00380, stallreq_ex=1 same cycle -> stall=0 that cycle; next cycle flush=1, new_pc_valid=1, new_pc=32'hBFC00380; following cycle flush=0.
REQ-033 TIMEOUT=4, stallreq_mem held 6 cycles -> stall_timeout=1 from cycle 5 on, stays 1 after release; stall_cycles=6.
REQ-034 stall_cycles preloaded near max (force to 32'hFFFFFFFE), 3 stall cycles -> reads 32'hFFFFFFFF, no wrap.
REQ-035 rst_n=0 during FLUSH cycle -> flush=0, new_pc_valid=0 that cycle and after release; state RUN.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stage stall requests and exception commit in,
// per-stage hold, flush and PC redirect out.
interface pipe_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic                stallreq_id;
    logic                stallreq_ex;
    logic                stallreq_mem;
    logic                excp_valid;
    logic [PC_WIDTH-1:0] excp_pc;
    logic [5:0]          stall;
    logic                flush;
    logic [PC_WIDTH-1:0] new_pc;
    logic                new_pc_valid;
    logic [31:0]         stall_cycles;
    logic                stall_timeout;

    // Pipeline side: raises requests, obeys hold/flush/redirect.
    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_pc,
        input  stall, flush, new_pc, new_pc_valid, stall_cycles, stall_timeout
    );

    // Controller side.
    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_pc,
        output stall, flush, new_pc, new_pc_valid, stall_cycles, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: prioritised stage stalls, one-cycle
// flush with PC redirect, stall statistics and a sticky stall watchdog.
module pipe_ctrl #(
    parameter int PC_WIDTH = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  pif,
    output logic        dbg_state
);
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t              state_q, state_nx;
    logic [5:0]          stall_c;
    logic                flush_c;
    logic                latch_pc;
    logic [PC_WIDTH-1:0] pc_q;
    logic [15:0]         consec_q;
    logic [31:0]         stall_cnt_q;
    logic                timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_nx;
    end

    // Exception beats every stall request; FLUSH ignores all inputs.
    always_comb begin
        state_nx = state_q;
        stall_c  = 6'b000000;
        flush_c  = 1'b0;
        latch_pc = 1'b0;
        if (rst_n) begin
            case (state_q)
                RUN: begin
                    if (pif.excp_valid) begin
                        latch_pc = 1'b1;
                        state_nx = FLUSH;
                    end else if (pif.stallreq_mem) begin
                        stall_c = 6'b011111;
                    end else if (pif.stallreq_ex) begin
                        stall_c = 6'b001111;
                    end else if (pif.stallreq_id) begin
                        stall_c = 6'b000111;
                    end
                end
                FLUSH: begin
                    flush_c  = 1'b1;
                    state_nx = RUN;
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)        pc_q <= '0;
        else if (latch_pc) pc_q <= pif.excp_pc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            consec_q    <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else if (stall_c != 6'b000000) begin
            if (consec_q != TO_LIMIT)        consec_q    <= consec_q + 16'd1;
            if (stall_cnt_q != 32'hFFFFFFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
            // Set on the edge where the run length reaches the limit.
            if (consec_q >= TO_LIMIT - 16'd1) timeout_q  <= 1'b1;
        end else begin
            consec_q <= '0;
        end
    end

    assign pif.stall         = stall_c;
    assign pif.flush         = flush_c;
    assign pif.new_pc_valid  = flush_c;
    assign pif.new_pc        = pc_q;
    assign pif.stall_cycles  = stall_cnt_q;
    assign pif.stall_timeout = timeout_q;
    assign dbg_state         = (state_q == FLUSH);
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model and a redirect scoreboard.
module tb_pipe_ctrl;
    localparam int PW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_state;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.PC_WIDTH(PW)) pif();

    pipe_ctrl #(.PC_WIDTH(PW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pif       (pif),
        .dbg_state (dbg_state)
    );

    // Behavioural model state
    bit          m_flush;
    logic [31:0] m_pc;
    int          m_consec;
    longint      m_cycles;
    bit          m_timeout;
    logic [PW-1:0] exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hold depth grows with the stalling stage: ID freezes 3 stages, EX 4, MEM 5.
    function automatic logic [5:0] model_stall(input bit rst, input bit flushing,
                                               input bit ev, input bit id,
                                               input bit ex, input bit mem);
        int depth;
        if (!rst || flushing || ev) return 6'd0;
        depth = mem ? 5 : ex ? 4 : id ? 3 : 0;
        return 6'((1 << depth) - 1);
    endfunction

    task automatic step(input bit id, input bit ex, input bit mem,
                        input bit ev, input logic [31:0] pc, input bit rst);
        logic [5:0] s;
        logic [PW-1:0] tgt;
        pif.stallreq_id  = id;
        pif.stallreq_ex  = ex;
        pif.stallreq_mem = mem;
        pif.excp_valid   = ev;
        pif.excp_pc      = pc;
        rst_n            = rst;
        s = model_stall(rst, m_flush, ev, id, ex, mem);
        @(negedge clk);
        check("stall",         pif.stall,         s);
        check("flush",         pif.flush,         rst && m_flush);
        check("new_pc_valid",  pif.new_pc_valid,  rst && m_flush);
        check("new_pc",        pif.new_pc,        m_pc);
        check("stall_cycles",  pif.stall_cycles,  64'(m_cycles));
        check("stall_timeout", pif.stall_timeout, m_timeout);
        check("dbg_state",     dbg_state,         m_flush);
        if (rst && m_flush) begin
            check("sb_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                tgt = exp_q.pop_front();
                check("sb_redirect", pif.new_pc, tgt);
            end
        end
        @(posedge clk);
        if (!rst) begin
            m_flush = 0; m_pc = '0; m_consec = 0; m_cycles = 0; m_timeout = 0;
            exp_q.delete();
        end else if (m_flush) begin
            m_flush = 0; m_consec = 0;
        end else if (ev) begin
            m_pc = pc; m_flush = 1; m_consec = 0;
            exp_q.push_back(pc);
        end else if (s != 6'd0) begin
            if (m_cycles < 64'hFFFFFFFF) m_cycles++;
            if (m_consec < TO) m_consec++;
            if (m_consec == TO) m_timeout = 1;
        end else begin
            m_consec = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 1);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 32'h0, 0);
        step(1, 1, 1, 1, 32'h1234, 0);
    endtask

    initial begin
        m_flush = 0; m_pc = '0; m_consec = 0; m_cycles = 0; m_timeout = 0;
        pif.stallreq_id = 0; pif.stallreq_ex = 0; pif.stallreq_mem = 0;
        pif.excp_valid = 0; pif.excp_pc = '0;
        @(posedge clk); #1;
        do_reset();

        // Three ID stalls then release
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0, 1);
        check("id3_cycles", pif.stall_cycles, 3);
        idle(1);

        // All requests together: MEM wins
        step(1, 1, 1, 0, 32'h0, 1);
        idle(1);

        // Exception beats an EX stall, then one flush cycle
        step(0, 1, 0, 1, 32'hBFC00380, 1);
        step(1, 1, 1, 1, 32'hDEADBEEF, 1);
        idle(1);
        check("excp_new_pc", pif.new_pc, 32'hBFC00380);

        // Watchdog: MEM held 6 cycles with limit 4
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 32'h0, 1);
        idle(2);
        check("wd_timeout", pif.stall_timeout, 1);
        check("wd_cycles",  pif.stall_cycles, 6);

        // Saturation of the total stall counter
        force dut.stall_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.stall_cnt_q;
        m_cycles = 64'hFFFFFFFE;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, 1);
        check("sat_cycles", pif.stall_cycles, 32'hFFFFFFFF);
        idle(1);

        // Reset landing on the flush cycle cancels the redirect
        step(0, 0, 0, 1, 32'h80000180, 1);
        step(0, 0, 0, 0, 32'h0, 0);
        idle(3);
        check("abort_pc", pif.new_pc, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 12) == 0,
                 $urandom, $urandom_range(0, 60) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
